// File: rtl/sd4_mac_pkg.sv
// Shared types and default sizing for the SD4 MAC sequencer.
package sd4_mac_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StClr,
    StRun,
    StDrain,
    StDone
  } sd4_state_e;

  localparam int unsigned SD4_PIPE_DEPTH = 4;
  localparam int unsigned SD4_LEN_W      = 8;

endpackage

// File: rtl/sd4_mac_vld_pipe.sv
// Valid-token shift register that tracks operand beats travelling through the MAC stages.
module sd4_mac_vld_pipe #(
  parameter int unsigned Depth = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic vld_in,
  output logic tail,
  output logic any
);

  logic [Depth-1:0] vld_q;
  logic [Depth-1:0] vld_d;

  assign vld_d = {vld_q[Depth-2:0], vld_in};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_q <= '0;
    end else if (en) begin
      vld_q <= vld_d;
    end
  end

  assign tail = vld_q[Depth-1];
  // Looks at the post-shift contents so the drain can end the cycle the last token retires.
  assign any  = |vld_d;

endmodule

// File: rtl/sd4_mac_seq_ctrl.sv
// SD4 MAC job sequencer: admits N beats, tracks tokens, drains, and hands off one result.
// Define SD4_MAC_PERF_EN to add the perf_bubbles input-starvation counter.
module sd4_mac_seq_ctrl
  import sd4_mac_pkg::*;
#(
  parameter int unsigned PIPE_DEPTH = SD4_PIPE_DEPTH,
  parameter int unsigned LEN_W      = SD4_LEN_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_valid,
  input  logic [LEN_W-1:0] cfg_len,
  output logic             cfg_ready,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             pipe_en,
  output logic             pipe_vld_in,
  output logic             acc_clr,
  output logic             acc_en,
  output logic             res_valid,
  input  logic             res_ready,
`ifdef SD4_MAC_PERF_EN
  output logic [15:0]      perf_bubbles,
`endif
  output logic             busy
);

  sd4_state_e       state_q, state_d;
  logic [LEN_W-1:0] remaining_q, remaining_d;
  logic             cfg_ready_q, in_ready_q, pipe_en_q, acc_clr_q, res_valid_q, busy_q;
  logic             fire;
  logic             vld_tail, vld_any;

  assign fire = in_valid & in_ready_q;

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    unique case (state_q)
      StIdle: begin
        if (cfg_valid) begin
          remaining_d = cfg_len;
          state_d     = StClr;
        end
      end
      StClr: begin
        state_d = (remaining_q == '0) ? StDone : StRun;
      end
      StRun: begin
        if (fire) begin
          remaining_d = remaining_q - LEN_W'(1);
          if (remaining_q == LEN_W'(1)) state_d = StDrain;
        end
      end
      StDrain: begin
        if (!vld_any) state_d = StDone;
      end
      StDone: begin
        if (res_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs are decoded from the next state so they are flops aligned with state_q.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      remaining_q <= '0;
      cfg_ready_q <= 1'b1;
      in_ready_q  <= 1'b0;
      pipe_en_q   <= 1'b0;
      acc_clr_q   <= 1'b0;
      res_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      cfg_ready_q <= (state_d == StIdle);
      in_ready_q  <= (state_d == StRun);
      pipe_en_q   <= (state_d == StClr) || (state_d == StRun) || (state_d == StDrain);
      acc_clr_q   <= (state_d == StClr);
      res_valid_q <= (state_d == StDone);
      busy_q      <= (state_d != StIdle);
    end
  end

  sd4_mac_vld_pipe #(
    .Depth (PIPE_DEPTH)
  ) u_vld_pipe (
    .clk    (clk),
    .rst    (rst),
    .en     (pipe_en_q),
    .vld_in (fire),
    .tail   (vld_tail),
    .any    (vld_any)
  );

`ifdef SD4_MAC_PERF_EN
  logic [15:0] perf_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_q <= '0;
    end else if (state_q == StClr) begin
      perf_q <= '0;
    end else if ((state_q == StRun) && !in_valid && (perf_q != 16'hFFFF)) begin
      perf_q <= perf_q + 16'd1;
    end
  end

  assign perf_bubbles = perf_q;
`endif

  assign cfg_ready   = cfg_ready_q;
  assign in_ready    = in_ready_q;
  assign pipe_en     = pipe_en_q;
  assign pipe_vld_in = fire;
  assign acc_clr     = acc_clr_q;
  assign acc_en      = vld_tail & pipe_en_q;
  assign res_valid   = res_valid_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_sd4_mac_seq_ctrl.sv
// Directed bench for sd4_mac_seq_ctrl with hand-computed per-cycle signal traces.
module tb_sd4_mac_seq_ctrl;

  logic       clk;
  logic       rst;
  logic       cfg_valid;
  logic [7:0] cfg_len;
  logic       cfg_ready;
  logic       in_valid;
  logic       in_ready;
  logic       pipe_en;
  logic       pipe_vld_in;
  logic       acc_clr;
  logic       acc_en;
  logic       res_valid;
  logic       res_ready;
  logic       busy;
`ifdef SD4_MAC_PERF_EN
  logic [15:0] perf_bubbles;
`endif

  int n_checks = 0;
  int n_errors = 0;

  sd4_mac_seq_ctrl #(
    .PIPE_DEPTH (4),
    .LEN_W      (8)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .cfg_valid    (cfg_valid),
    .cfg_len      (cfg_len),
    .cfg_ready    (cfg_ready),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .pipe_en      (pipe_en),
    .pipe_vld_in  (pipe_vld_in),
    .acc_clr      (acc_clr),
    .acc_en       (acc_en),
    .res_valid    (res_valid),
    .res_ready    (res_ready),
`ifdef SD4_MAC_PERF_EN
    .perf_bubbles (perf_bubbles),
`endif
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Handshake a job, then record 16 cycles starting at the CLR cycle (index 0).
  // in_valid follows pat[i] per cycle; pulse injects a stray cfg request at index 2.
  task automatic run_job(input logic [7:0] len, input logic [15:0] pat, input bit pulse,
                         output logic [15:0] fire_v, output logic [15:0] en_v,
                         output logic [15:0] clr_v, output logic [15:0] rv_v);
    fire_v    = '0;
    en_v      = '0;
    clr_v     = '0;
    rv_v      = '0;
    res_ready = 1'b0;
    cfg_len   = len;
    cfg_valid = 1'b1;
    step();
    for (int i = 0; i < 16; i++) begin
      in_valid  = pat[i];
      cfg_valid = pulse && (i == 2);
      cfg_len   = (pulse && (i == 2)) ? 8'd200 : len;
      #1;
      fire_v[i] = pipe_vld_in;
      en_v[i]   = acc_en;
      clr_v[i]  = acc_clr;
      rv_v[i]   = res_valid;
      step();
    end
    in_valid  = 1'b0;
    cfg_valid = 1'b0;
  endtask

  task automatic finish_job(input string tag);
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    check({tag, "_idle_cfg_ready"}, {31'd0, cfg_ready}, 32'd1);
    check({tag, "_idle_res_valid"}, {31'd0, res_valid}, 32'd0);
  endtask

  logic [15:0] f, e, c, r;
  int          en_after;

  initial begin
    rst       = 1'b0;
    cfg_valid = 1'b0;
    cfg_len   = '0;
    in_valid  = 1'b0;
    res_ready = 1'b0;
    step();
    step();
    check("rst_cfg_ready", {31'd0, cfg_ready}, 32'd1);
    check("rst_busy",      {31'd0, busy},      32'd0);
    check("rst_acc_clr",   {31'd0, acc_clr},   32'd0);
    check("rst_res_valid", {31'd0, res_valid}, 32'd0);
    check("rst_pipe_en",   {31'd0, pipe_en},   32'd0);
    check("rst_in_ready",  {31'd0, in_ready},  32'd0);
    rst = 1'b1;
    step();

    // Stray res_ready in IDLE does nothing.
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    check("idle_res_ready_busy", {31'd0, busy}, 32'd0);

    // 1: len 3, in_valid held high.
    run_job(8'd3, 16'hFFFF, 1'b0, f, e, c, r);
    check("t1_fire",  {16'd0, f}, 32'h000E);
    check("t1_accen", {16'd0, e}, 32'h00E0);
    check("t1_clr",   {16'd0, c}, 32'h0001);
    check("t1_rv",    {16'd0, r}, 32'hFF00);
`ifdef SD4_MAC_PERF_EN
    check("t1_perf", {16'd0, perf_bubbles}, 32'd0);
`endif
    // 4: hold the result for 10 more cycles.
    for (int i = 0; i < 10; i++) begin
      check("t4_rv_hold",   {31'd0, res_valid}, 32'd1);
      check("t4_pipe_en",   {31'd0, pipe_en},   32'd0);
      check("t4_cfg_ready", {31'd0, cfg_ready}, 32'd0);
      step();
    end
    finish_job("t4");

    // 2: len 4, in_valid alternating from the first RUN cycle.
    run_job(8'd4, 16'h00AA, 1'b0, f, e, c, r);
    check("t2_fire",  {16'd0, f}, 32'h00AA);
    check("t2_accen", {16'd0, e}, 32'h0AA0);
    check("t2_clr",   {16'd0, c}, 32'h0001);
    check("t2_rv",    {16'd0, r}, 32'hF000);
`ifdef SD4_MAC_PERF_EN
    check("t2_perf", {16'd0, perf_bubbles}, 32'd3);
`endif
    finish_job("t2");

    // 3: zero-length job.
    run_job(8'd0, 16'hFFFF, 1'b0, f, e, c, r);
    check("t3_fire",  {16'd0, f}, 32'h0000);
    check("t3_accen", {16'd0, e}, 32'h0000);
    check("t3_clr",   {16'd0, c}, 32'h0001);
    check("t3_rv",    {16'd0, r}, 32'hFFFE);
    finish_job("t3");

    // 5: stray cfg request during RUN must not change the job.
    run_job(8'd3, 16'hFFFF, 1'b1, f, e, c, r);
    check("t5_fire",  {16'd0, f}, 32'h000E);
    check("t5_accen", {16'd0, e}, 32'h00E0);
    check("t5_rv",    {16'd0, r}, 32'hFF00);
    finish_job("t5");

    // 6: reset during DRAIN with two tokens in flight.
    cfg_len   = 8'd2;
    cfg_valid = 1'b1;
    in_valid  = 1'b1;
    step();
    cfg_valid = 1'b0;
    step();
    step();
    step();
    check("t6_drain_in_ready", {31'd0, in_ready}, 32'd0);
    check("t6_drain_pipe_en",  {31'd0, pipe_en},  32'd1);
    check("t6_vld_sr_pre",     {28'd0, dut.u_vld_pipe.vld_q}, 32'h3);
    in_valid = 1'b0;
    rst      = 1'b0;
    #1;
    check("t6_rst_busy",      {31'd0, busy},      32'd0);
    check("t6_rst_cfg_ready", {31'd0, cfg_ready}, 32'd1);
    check("t6_rst_vld_sr",    {28'd0, dut.u_vld_pipe.vld_q}, 32'h0);
    step();
    step();
    rst      = 1'b1;
    en_after = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (acc_en) en_after++;
    end
    check("t6_acc_en_after", en_after, 32'd0);
    check("t6_idle",         {31'd0, cfg_ready}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
